// File: rtl/score_pkg.sv
// Shared types, constants and BCD helpers for the score accumulator/display stage.
package score_pkg;

    typedef enum logic {PLAY, DEAD} tally_state_t;

    localparam int unsigned BCD_W   = 12;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    localparam logic [BCD_W-1:0] SCORE_MAX_BCD = 12'h999;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DIGITS [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Decimal +1 with carry rippling through the three digits
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Strict greater-than, most significant digit first
    function automatic logic bcd_gt(input logic [BCD_W-1:0] a, input logic [BCD_W-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
                gt      = (a[i*4 +: 4] > b[i*4 +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/seg7_bcd.sv
// One BCD digit to active-low 7-segment pattern; non-BCD codes blank the digit.
module seg7_bcd
    import score_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg_n = SEG_DIGITS[bcd];
        end
    end

endmodule

// File: rtl/score_tally.sv
// Counts score pulses into a saturating 3-digit BCD score, tracks the best score
// across games and alternates current/best on the display after game over.
module score_tally
    import score_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES = 25_000_000
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             Score,
    input  logic             Over,
    input  logic             NewGame,
    output logic [BCD_W-1:0] CurBCD,
    output logic [BCD_W-1:0] BestBCD,
    output logic             NewBest,
    output logic [SEG_W-1:0] HEX0,
    output logic [SEG_W-1:0] HEX1,
    output logic [SEG_W-1:0] HEX2
);

    localparam int unsigned PHASE_W = $clog2(BLINK_CYCLES);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BLINK_CYCLES - 1);

    tally_state_t     state_q, state_d;
    logic [BCD_W-1:0] cur_q, cur_d;
    logic [BCD_W-1:0] best_q, best_d;
    logic             new_best_q, new_best_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic             show_best_q, show_best_d;
    logic [BCD_W-1:0] disp_bcd;

    // Next-state: NewGame overrides everything, then per-state behaviour
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        best_d      = best_q;
        new_best_d  = new_best_q;
        phase_d     = phase_q;
        show_best_d = show_best_q;

        if (NewGame) begin
            state_d     = PLAY;
            cur_d       = '0;
            new_best_d  = 1'b0;
            phase_d     = '0;
            show_best_d = 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (Over) begin
                        state_d     = DEAD;
                        phase_d     = '0;
                        show_best_d = 1'b0;
                        if (bcd_gt(cur_q, best_q)) begin
                            best_d     = cur_q;
                            new_best_d = 1'b1;
                        end else begin
                            new_best_d = 1'b0;
                        end
                    end else if (Score && (cur_q != SCORE_MAX_BCD)) begin
                        cur_d = bcd_inc(cur_q);
                    end
                end
                DEAD: begin
                    if (phase_q == PHASE_LAST) begin
                        phase_d     = '0;
                        show_best_d = ~show_best_q;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
                default: state_d = PLAY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q     <= PLAY;
            cur_q       <= '0;
            best_q      <= '0;
            new_best_q  <= 1'b0;
            phase_q     <= '0;
            show_best_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            best_q      <= best_d;
            new_best_q  <= new_best_d;
            phase_q     <= phase_d;
            show_best_q <= show_best_d;
        end
    end

    assign CurBCD  = cur_q;
    assign BestBCD = best_q;
    assign NewBest = new_best_q;

    assign disp_bcd = ((state_q == DEAD) && show_best_q) ? best_q : cur_q;

    seg7_bcd u_seg_ones     (.bcd(disp_bcd[3:0]),  .seg_n(HEX0));
    seg7_bcd u_seg_tens     (.bcd(disp_bcd[7:4]),  .seg_n(HEX1));
    seg7_bcd u_seg_hundreds (.bcd(disp_bcd[11:8]), .seg_n(HEX2));

endmodule
